booth_r8_decode_acc: RTL



---
 rtl/booth_r8_decode_acc_pkg.sv | 27 ++
 rtl/booth_r8_decode_acc_if.sv | 31 +++
 rtl/booth_r8_digit_dec.sv | 41 ++++
 rtl/booth_r8_decode_acc.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/booth_r8_decode_acc_pkg.sv
// Shared definitions for the radix-8 Booth digit path: digit code map, FSM states, digit weight.
// Latency: n/a (constants only).
// Backpressure: n/a.
package booth_pkg;

  // Bits of multiplier covered by one radix-8 digit (weight 8 = 2**3).
  localparam int BOOTH_DIG_BITS = 3;

  // Digit codes; each negative code is the bitwise complement of its positive twin.
  localparam logic [3:0] BOOTH_P0 = 4'b0101;
  localparam logic [3:0] BOOTH_P1 = 4'b0001;
  localparam logic [3:0] BOOTH_P2 = 4'b0010;
  localparam logic [3:0] BOOTH_P3 = 4'b0100;
  localparam logic [3:0] BOOTH_P4 = 4'b1000;
  localparam logic [3:0] BOOTH_N0 = 4'b1010;
  localparam logic [3:0] BOOTH_N1 = 4'b1110;
  localparam logic [3:0] BOOTH_N2 = 4'b1101;
  localparam logic [3:0] BOOTH_N3 = 4'b1011;
  localparam logic [3:0] BOOTH_N4 = 4'b0111;

  // Accumulator FSM states.
  typedef logic [1:0] booth_state_t;
  localparam booth_state_t ST_IDLE  = 2'd0;
  localparam booth_state_t ST_ACCUM = 2'd1;
  localparam booth_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/booth_r8_decode_acc_if.sv
// Bundle between the digit source / writeback side and the Booth decode-accumulator.
// Latency: n/a (wires only).
// Backpressure: DIG_READY qualifies DIG_VALID; START is only honoured while the block is idle.
// master: drives START, MCAND, DIG_VALID, DIG_CODE; observes DIG_READY, BUSY, PROD, PROD_VALID, ERR.
// slave : the accumulator, the mirror image of master.
interface booth_r8_decode_acc_if #(
  parameter int MCAND_W = 16,
  parameter int NDIG    = 6
) ();
  localparam int PROD_W = MCAND_W + booth_pkg::BOOTH_DIG_BITS * NDIG;

  logic                      START;
  logic signed [MCAND_W-1:0] MCAND;
  logic                      DIG_VALID;
  logic [3:0]                DIG_CODE;
  logic                      DIG_READY;
  logic                      BUSY;
  logic signed [PROD_W-1:0]  PROD;
  logic                      PROD_VALID;
  logic                      ERR;

  modport master (
    output START, MCAND, DIG_VALID, DIG_CODE,
    input  DIG_READY, BUSY, PROD, PROD_VALID, ERR
  );

  modport slave (
    input  START, MCAND, DIG_VALID, DIG_CODE,
    output DIG_READY, BUSY, PROD, PROD_VALID, ERR
  );
endinterface

// File: rtl/booth_r8_digit_dec.sv
// Combinational decode of a 4-bit radix-8 Booth digit code into sign, one-hot magnitude select, zero, illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: code in; neg, sel1..sel4 (one-hot magnitude), zero (+0/-0), illegal (6 unused codes) out.
module booth_r8_digit_dec
  import booth_pkg::*;
(
  input  logic [3:0] code,
  output logic       neg,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       zero,
  output logic       illegal
);

  always_comb begin
    neg     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel3    = 1'b0;
    sel4    = 1'b0;
    zero    = 1'b0;
    illegal = 1'b0;
    case (code)
      BOOTH_P0: zero = 1'b1;
      BOOTH_P1: sel1 = 1'b1;
      BOOTH_P2: sel2 = 1'b1;
      BOOTH_P3: sel3 = 1'b1;
      BOOTH_P4: sel4 = 1'b1;
      BOOTH_N0: begin neg = 1'b1; zero = 1'b1; end
      BOOTH_N1: begin neg = 1'b1; sel1 = 1'b1; end
      BOOTH_N2: begin neg = 1'b1; sel2 = 1'b1; end
      BOOTH_N3: begin neg = 1'b1; sel3 = 1'b1; end
      BOOTH_N4: begin neg = 1'b1; sel4 = 1'b1; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_r8_decode_acc.sv
// Radix-8 Booth receive side: decodes LSD-first digit codes, accumulates digit*MCAND*8^i, emits signed product.
// Latency: START->first digit accept 1 cycle; last accept->PROD_VALID 1 cycle; min op NDIG+2 cycles.
// Backpressure: DIG_READY high only in ACCUM; DIG_VALID low stalls with all state held.
// Ports: CLK, RST (async, active-high); bus (slave modport): START/MCAND in, DIG_VALID/DIG_CODE/DIG_READY
//        digit handshake, BUSY, PROD/PROD_VALID result, ERR illegal-code flag.
// Build option: BOOTH_DIG_CHECK_EN enables sticky ERR on illegal codes; otherwise ERR is tied low.
module booth_r8_decode_acc
  import booth_pkg::*;
#(
  parameter int MCAND_W = 16,
  parameter int NDIG    = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  booth_r8_decode_acc_if.slave bus
);

  localparam int PROD_W = MCAND_W + BOOTH_DIG_BITS * NDIG;
  localparam int PP_W   = MCAND_W + 3;
  localparam int CNT_W  = $clog2(NDIG + 1);

  booth_state_t              state_q, state_d;
  logic signed [MCAND_W-1:0] mcand_q, mcand_d;
  logic signed [MCAND_W+1:0] mcand3_q, mcand3_d;
  logic signed [PROD_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic dec_neg, dec_sel1, dec_sel2, dec_sel3, dec_sel4, dec_zero, dec_illegal;
  logic dig_acc;

  logic signed [PP_W-1:0]    mc_ext, mag, pp;
  logic signed [PROD_W-1:0]  pp_sh;
  logic signed [MCAND_W+1:0] mc2;
  logic [7:0]                sh_amt;

  booth_r8_digit_dec u_dec (
    .code    (bus.DIG_CODE),
    .neg     (dec_neg),
    .sel1    (dec_sel1),
    .sel2    (dec_sel2),
    .sel3    (dec_sel3),
    .sel4    (dec_sel4),
    .zero    (dec_zero),
    .illegal (dec_illegal)
  );

  assign dig_acc = (state_q == ST_ACCUM) && bus.DIG_VALID;

  // Partial product, then placed at weight 8^cnt within the product width.
  always_comb begin
    mc_ext = PP_W'(mcand_q);
    mag    = '0;
    // Zero/illegal codes never assert a select; the guard makes "contributes 0" explicit.
    if (!dec_zero && !dec_illegal) begin
      if (dec_sel1)      mag = mc_ext;
      else if (dec_sel2) mag = mc_ext <<< 1;
      else if (dec_sel3) mag = PP_W'(mcand3_q);
      else if (dec_sel4) mag = mc_ext <<< 2;
    end
    pp     = dec_neg ? -mag : mag;
    sh_amt = 8'(cnt_q) * 8'(BOOTH_DIG_BITS);
    pp_sh  = PROD_W'(pp) <<< sh_amt;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mcand3_d = mcand3_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mc2      = (MCAND_W + 2)'(bus.MCAND);
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d  = ST_ACCUM;
          mcand_d  = bus.MCAND;
          // 3*MCAND formed once here so the +/-3 digits need no adder in the digit path.
          mcand3_d = mc2 + (mc2 <<< 1);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_ACCUM: begin
        if (dig_acc) begin
          acc_d = acc_q + pp_sh;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIG - 1)) begin
            state_d = ST_DONE;
            prod_d  = acc_q + pp_sh;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mcand3_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mcand3_q <= mcand3_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

`ifdef BOOTH_DIG_CHECK_EN
  logic err_q, err_d;

  // Sticky from the first illegal accept until the next accepted START.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && bus.START) err_d = 1'b0;
    else if (dig_acc && dec_illegal)       err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.DIG_READY  = (state_q == ST_ACCUM);
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.PROD_VALID = (state_q == ST_DONE);
  assign bus.PROD       = prod_q;

endmodule
